fp_sum3_operand_sequencer: RTL

//  Feeds DW_fp_sum3_DG (which sits directly downstream) from one FP operand stream with valid/ready.

---
 rtl/fp_sum3_operand_sequencer_if.sv | 44 ++++
 rtl/fp_sum3_operand_sequencer.sv | 99 +++++++++
 2 files changed

// File: rtl/fp_sum3_operand_sequencer_if.sv
// Operand stream in, adder operand/result port, and registered result stream out.
interface fp_sum3_operand_sequencer_if #(
  parameter int sig_width = 23,
  parameter int exp_width = 8
);
  localparam int W = sig_width + exp_width + 1;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic [2:0]   in_rnd;

  logic [W-1:0] sum_a;
  logic [W-1:0] sum_b;
  logic [W-1:0] sum_c;
  logic [2:0]   sum_rnd;
  logic         sum_DG_ctrl;
  logic [W-1:0] sum_z;
  logic [7:0]   sum_status;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_z;
  logic [7:0]   out_status;

  modport slave (
    input  in_valid, in_data, in_last, in_rnd,
    output in_ready,
    output sum_a, sum_b, sum_c, sum_rnd, sum_DG_ctrl,
    input  sum_z, sum_status,
    output out_valid, out_z, out_status,
    input  out_ready
  );

  modport master (
    output in_valid, in_data, in_last, in_rnd,
    input  in_ready,
    input  sum_a, sum_b, sum_c, sum_rnd, sum_DG_ctrl,
    output sum_z, sum_status,
    input  out_valid, out_z, out_status,
    output out_ready
  );
endinterface

// File: rtl/fp_sum3_operand_sequencer.sv
// Packs an FP operand stream into a/b/c triplets (short groups padded with +0) for a DG-gated 3-input adder.
// Latency: last operand accepted at t -> DG_ctrl high at t+1 -> out_valid at t+2.
// Backpressure: a full, unpopped result register holds the issue state, which drops in_ready.
module fp_sum3_operand_sequencer #(
  parameter int sig_width = 23,
  parameter int exp_width = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  fp_sum3_operand_sequencer_if.slave  bus
);
  localparam int W = sig_width + exp_width + 1;

  localparam logic [1:0] S_A     = 2'd0;
  localparam logic [1:0] S_B     = 2'd1;
  localparam logic [1:0] S_C     = 2'd2;
  localparam logic [1:0] S_ISSUE = 2'd3;

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic [W-1:0] sum_a;
  logic [W-1:0] sum_b;
  logic [W-1:0] sum_c;
  logic [2:0]   sum_rnd;
  logic         dg_ctrl;
  logic         out_valid;
  logic [W-1:0] out_z;
  logic [7:0]   out_status;
  logic         in_ready;
  logic         xfer;
  logic         capture;

  assign in_ready = !rst && (state != S_ISSUE);
  assign xfer     = bus.in_valid && in_ready;
  assign capture  = (state == S_ISSUE) && (!out_valid || bus.out_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      S_A:     if (xfer) state_nxt = bus.in_last ? S_ISSUE : S_B;
      S_B:     if (xfer) state_nxt = bus.in_last ? S_ISSUE : S_C;
      S_C:     if (xfer) state_nxt = S_ISSUE;
      default: if (capture) state_nxt = S_A;
    endcase
  end

  // Operand registers only change on accepted operands so the gated adder sees no toggling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_A;
      sum_a      <= '0;
      sum_b      <= '0;
      sum_c      <= '0;
      sum_rnd    <= '0;
      dg_ctrl    <= 1'b0;
      out_valid  <= 1'b0;
      out_z      <= '0;
      out_status <= '0;
    end else begin
      state   <= state_nxt;
      dg_ctrl <= (state_nxt == S_ISSUE);
      if (xfer) begin
        case (state)
          S_A: begin
            sum_a   <= bus.in_data;
            sum_rnd <= bus.in_rnd;
            if (bus.in_last) begin
              sum_b <= '0;
              sum_c <= '0;
            end
          end
          S_B: begin
            sum_b <= bus.in_data;
            if (bus.in_last) sum_c <= '0;
          end
          S_C:     sum_c <= bus.in_data;
          default: ;
        endcase
      end
      if (capture) begin
        out_z      <= bus.sum_z;
        out_status <= bus.sum_status;
        out_valid  <= 1'b1;
      end else if (out_valid && bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.sum_a       = sum_a;
  assign bus.sum_b       = sum_b;
  assign bus.sum_c       = sum_c;
  assign bus.sum_rnd     = sum_rnd;
  assign bus.sum_DG_ctrl = dg_ctrl;
  assign bus.out_valid   = out_valid;
  assign bus.out_z       = out_z;
  assign bus.out_status  = out_status;
endmodule
